// File: rtl/dff_deser_if.sv
// Serial-in / parallel-out handshake bundle for dff_deser.
// master = upstream bit source plus downstream word consumer; slave = deserializer.
interface dff_deser_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic             din;
    logic             din_vld;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             dout_rdy;
    logic             ovf;
    logic             ovf_clr;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output din, din_vld, dout_rdy, ovf_clr,
        input  dout, dout_vld, ovf, bit_cnt
    );

    modport slave (
        input  din, din_vld, dout_rdy, ovf_clr,
        output dout, dout_vld, ovf, bit_cnt
    );
endinterface

// File: rtl/dff_deser.sv
// Serial-to-parallel deserializer with a single-entry output register and a sticky
// overflow flag; the serial side never stalls, so words that cannot be stored are dropped.
module dff_deser #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    dff_deser_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shift_q, shift_d, shift_nxt;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic             ovf_q, ovf_d;
    logic             word_done;
    logic             ovf_evt;

    // Shift direction decides which end of the word the first received bit ends up in.
    always_comb begin
        shift_nxt = shift_q;
        if (MSB_FIRST) begin
            shift_nxt = {shift_q[WIDTH-2:0], bus.din};
        end else begin
            shift_nxt = {bus.din, shift_q[WIDTH-1:1]};
        end
    end

    // Bit accumulation and output-register load/drop decisions.
    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        ovf_d      = ovf_q;
        word_done  = 1'b0;
        ovf_evt    = 1'b0;

        if (bus.din_vld) begin
            shift_d = shift_nxt;
            if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                bit_cnt_d = '0;
                word_done = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end

        // A finished word may take the slot only if it is empty or draining this cycle.
        if (word_done && (!dout_vld_q || bus.dout_rdy)) begin
            dout_d     = shift_nxt;
            dout_vld_d = 1'b1;
        end else if (word_done) begin
            ovf_evt = 1'b1;
        end else if (dout_vld_q && bus.dout_rdy) begin
            dout_vld_d = 1'b0;
        end

        if (ovf_evt) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.ovf      = ovf_q;
    assign bus.bit_cnt  = bit_cnt_q;
endmodule

// File: tb/tb_dff_deser.sv
// Bench for dff_deser: MSB-first and LSB-first instances driven in lockstep and compared
// every cycle against a bit-list reference model, plus directed word-value checks.
module tb_dff_deser;
    localparam int unsigned W = 8;

    logic clk;
    logic rst;

    dff_deser_if #(.WIDTH(W)) if0 ();
    dff_deser_if #(.WIDTH(W)) if1 ();

    dff_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(if0.slave));
    dff_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: bits of the current partial word in arrival order, plus output slots.
    int          bits[$];
    logic [31:0] m_dout [2];
    bit          m_vld  [2];
    bit          m_ovf  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // k=0: first bit is the word's MSB; k=1: first bit is the word's LSB.
    function automatic logic [31:0] build_word(input int k);
        logic [31:0] w = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (bits[i] != 0) w += (k == 0) ? (32'd1 << (W - 1 - i)) : (32'd1 << i);
        end
        return w;
    endfunction

    task automatic model_step(input bit r, input bit dv, input bit d, input bit rdy, input bit clr);
        bit          done = 1'b0;
        logic [31:0] word [2];
        bit          drop;
        if (r) begin
            bits.delete();
            for (int k = 0; k < 2; k++) begin
                m_dout[k] = 0; m_vld[k] = 1'b0; m_ovf[k] = 1'b0;
            end
            return;
        end
        if (dv) begin
            bits.push_back(int'(d));
            if (bits.size() == int'(W)) begin
                done = 1'b1;
                word[0] = build_word(0);
                word[1] = build_word(1);
                bits.delete();
            end
        end
        for (int k = 0; k < 2; k++) begin
            drop = done && m_vld[k] && !rdy;
            if (done && !drop) begin
                m_dout[k] = word[k];
                m_vld[k]  = 1'b1;
            end else if (!done && m_vld[k] && rdy) begin
                m_vld[k] = 1'b0;
            end
            if (drop)     m_ovf[k] = 1'b1;
            else if (clr) m_ovf[k] = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("dout_m",    32'(if0.dout),     m_dout[0]);
        check("vld_m",     32'(if0.dout_vld), 32'(m_vld[0]));
        check("ovf_m",     32'(if0.ovf),      32'(m_ovf[0]));
        check("cnt_m",     32'(if0.bit_cnt),  32'(bits.size()));
        check("dout_l",    32'(if1.dout),     m_dout[1]);
        check("vld_l",     32'(if1.dout_vld), 32'(m_vld[1]));
        check("ovf_l",     32'(if1.ovf),      32'(m_ovf[1]));
        check("cnt_l",     32'(if1.bit_cnt),  32'(bits.size()));
    endtask

    // One clock: drive inputs, update model at the edge, sample 1 time unit later.
    task automatic cyc(input bit r, input bit dv, input bit d, input bit rdy, input bit clr);
        rst         = r;
        if0.din     = d;   if1.din     = d;
        if0.din_vld = dv;  if1.din_vld = dv;
        if0.dout_rdy = rdy; if1.dout_rdy = rdy;
        if0.ovf_clr = clr; if1.ovf_clr = clr;
        @(posedge clk);
        model_step(r, dv, d, rdy, clr);
        #1;
        compare_all();
    endtask

    // Feed w[W-1] first; last bit may use different rdy/clr; optional idle cycle before each bit.
    task automatic send_word(input logic [7:0] w, input bit rdy, input bit rdy_last,
                             input bit clr_last, input bit gaps);
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (gaps) cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0);
            cyc(1'b0, 1'b1, w[i], (i == 0) ? rdy_last : rdy, (i == 0) ? clr_last : 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        if0.din = 0; if0.din_vld = 0; if0.dout_rdy = 0; if0.ovf_clr = 0;
        if1.din = 0; if1.din_vld = 0; if1.dout_rdy = 0; if1.ovf_clr = 0;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1);
        check("rst_dout", 32'(if0.dout), 32'h0);
        check("rst_cnt",  32'(if0.bit_cnt), 32'h0);

        // Basic word in both bit orders.
        send_word(8'hC1, 1, 1, 0, 0);
        check("c1_msb", 32'(if0.dout), 32'hC1);
        check("c1_lsb", 32'(if1.dout), 32'h83);
        check("c1_vld", 32'(if0.dout_vld), 32'h1);
        cyc(0, 0, 0, 1, 0);
        check("c1_vld_drop", 32'(if0.dout_vld), 32'h0);

        // Overflow: second word dropped while first is held.
        send_word(8'hC1, 0, 0, 0, 0);
        send_word(8'h5A, 0, 0, 0, 0);
        check("ovf_hold", 32'(if0.dout), 32'hC1);
        check("ovf_set",  32'(if0.ovf), 32'h1);
        cyc(0, 0, 0, 1, 0);
        check("ovf_xfer", 32'(if0.dout_vld), 32'h0);
        cyc(0, 0, 0, 0, 1);
        check("ovf_clr", 32'(if0.ovf), 32'h0);

        // Transfer in the same cycle the next word completes.
        send_word(8'hC1, 0, 0, 0, 0);
        send_word(8'h3C, 0, 1, 0, 0);
        check("b2b_dout", 32'(if0.dout), 32'h3C);
        check("b2b_vld",  32'(if0.dout_vld), 32'h1);
        check("b2b_ovf",  32'(if0.ovf), 32'h0);
        cyc(0, 0, 0, 1, 0);

        // Reset mid-word discards partial bits.
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 0);
        check("mid_cnt5", 32'(if0.bit_cnt), 32'h5);
        cyc(1, 0, 0, 0, 0);
        check("mid_cnt0", 32'(if0.bit_cnt), 32'h0);
        send_word(8'hC1, 1, 1, 0, 0);
        check("mid_c1", 32'(if0.dout), 32'hC1);
        cyc(0, 0, 0, 1, 0);

        // Gapped input, then overflow coinciding with ovf_clr.
        send_word(8'hC1, 1, 1, 0, 1);
        check("gap_c1",  32'(if0.dout), 32'hC1);
        check("gap_lsb", 32'(if1.dout), 32'h83);
        send_word(8'h5A, 0, 0, 1, 1);
        check("clr_ovf", 32'(if0.ovf), 32'h1);
        check("clr_hold", 32'(if0.dout), 32'hC1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
